// File: rtl/rs_berlekamp_massey.sv
// Berlekamp-Massey key-equation solver for RS(15,11) over GF(16): serial syndromes in, error locator out.
// Optional error-evaluator outputs OMEGA0/OMEGA1 exist only when RS_BM_OMEGA_EN is defined.
module rs_berlekamp_massey #(
  parameter int         GF_M = 4,
  parameter int         NSYN = 4,
  parameter logic [4:0] POLY = 5'b10011
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [GF_M-1:0] SYN_IN,
  input  logic            SYN_VALID,
  output logic            BUSY,
  output logic            DONE,
  output logic [GF_M-1:0] LAMBDA1,
  output logic [GF_M-1:0] LAMBDA2,
  output logic [2:0]      L_DEG,
  output logic            NO_ERROR,
  output logic            FAIL
`ifdef RS_BM_OMEGA_EN
  ,
  output logic [GF_M-1:0] OMEGA0,
  output logic [GF_M-1:0] OMEGA1
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DISC, ST_UPDT, ST_FINISH} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_cnt;
  logic [GF_M-1:0] r_syn [0:NSYN-1];
  logic [GF_M-1:0] r_lam [0:4];
  logic [GF_M-1:0] r_bp  [0:4];
  logic [GF_M-1:0] r_b, r_d;
  logic [2:0]      r_len, r_r;
  logic            r_done, r_no_err, r_fail;
  logic [GF_M-1:0] r_lambda1, r_lambda2;
  logic [2:0]      r_ldeg;
`ifdef RS_BM_OMEGA_EN
  logic [GF_M-1:0] r_omega0, r_omega1;
`endif

  logic [GF_M-1:0] w_disc, w_scale;
  logic [GF_M-1:0] w_xb      [0:4];
  logic [GF_M-1:0] w_t       [0:4];
  logic [GF_M-1:0] w_lam_nxt [0:4];
  logic [2:0]      w_len_nxt, w_deg;
  logic            w_grow, w_fail, w_no_err;

  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
    logic [GF_M-1:0] acc, sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < GF_M; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = sh[GF_M-1] ? ((sh << 1) ^ POLY[GF_M-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [GF_M-1:0] gf_inv(input logic [GF_M-1:0] a);
    logic [GF_M-1:0] v;
    case (a)
      4'h1: v = 4'h1;  4'h2: v = 4'h9;  4'h3: v = 4'hE;  4'h4: v = 4'hD;
      4'h5: v = 4'hB;  4'h6: v = 4'h7;  4'h7: v = 4'h6;  4'h8: v = 4'hF;
      4'h9: v = 4'h2;  4'hA: v = 4'hC;  4'hB: v = 4'h5;  4'hC: v = 4'hA;
      4'hD: v = 4'h4;  4'hE: v = 4'h3;  4'hF: v = 4'h8;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (SYN_VALID && (r_cnt == 2'(NSYN-1))) w_next = ST_DISC;
      ST_DISC:   w_next = ST_UPDT;
      ST_UPDT:   w_next = (r_r == 3'd4) ? ST_FINISH : ST_DISC;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Discrepancy d = S_r + sum Lambda_i * S_(r-i); syndrome j holds S_(j+1)
  always_comb begin
    w_disc = '0;
    for (int j = 0; j < NSYN; j++)
      if (3'(j + 1) == r_r) w_disc = w_disc ^ r_syn[j];
    for (int i = 1; i < NSYN; i++)
      for (int j = 0; j < NSYN; j++)
        if ((3'(i) < r_r) && (3'(i + j + 1) == r_r))
          w_disc = w_disc ^ gf_mul(r_lam[i], r_syn[j]);
  end

  always_comb begin
    w_scale   = gf_mul(r_d, gf_inv(r_b));
    w_grow    = 1'b0;
    w_len_nxt = r_len;
    w_xb[0]   = '0;
    for (int k = 1; k < 5; k++) w_xb[k] = r_bp[k-1];
    for (int k = 0; k < 5; k++) begin
      w_t[k]       = r_lam[k] ^ gf_mul(w_scale, w_xb[k]);
      w_lam_nxt[k] = r_lam[k];
    end
    if (r_d != '0) begin
      for (int k = 0; k < 5; k++) w_lam_nxt[k] = w_t[k];
      if ({r_len, 1'b0} <= {1'b0, r_r - 3'd1}) begin
        w_grow    = 1'b1;
        w_len_nxt = r_r - r_len;
      end
    end
  end

  // Result qualification on the locator as it will stand after the final update
  always_comb begin
    w_deg = 3'd0;
    for (int k = 1; k < 5; k++)
      if (w_lam_nxt[k] != '0) w_deg = 3'(k);
    w_fail   = (w_len_nxt > 3'd2) || (w_lam_nxt[3] != '0) || (w_lam_nxt[4] != '0) ||
               (w_deg != w_len_nxt);
    w_no_err = 1'b1;
    for (int j = 0; j < NSYN; j++)
      if (r_syn[j] != '0) w_no_err = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt     <= '0;
      r_r       <= '0;
      r_d       <= '0;
      r_b       <= 4'h1;
      r_len     <= '0;
      r_done    <= 1'b0;
      r_no_err  <= 1'b0;
      r_fail    <= 1'b0;
      r_lambda1 <= '0;
      r_lambda2 <= '0;
      r_ldeg    <= '0;
`ifdef RS_BM_OMEGA_EN
      r_omega0  <= '0;
      r_omega1  <= '0;
`endif
      for (int j = 0; j < NSYN; j++) r_syn[j] <= '0;
      for (int k = 0; k < 5; k++) begin
        r_lam[k] <= (k == 0) ? 4'h1 : 4'h0;
        r_bp[k]  <= (k == 0) ? 4'h1 : 4'h0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (SYN_VALID) begin
            r_syn[r_cnt] <= SYN_IN;
            if (r_cnt == 2'(NSYN-1)) begin
              r_cnt <= '0;
              r_r   <= 3'd1;
              r_b   <= 4'h1;
              r_len <= '0;
              for (int k = 0; k < 5; k++) begin
                r_lam[k] <= (k == 0) ? 4'h1 : 4'h0;
                r_bp[k]  <= (k == 0) ? 4'h1 : 4'h0;
              end
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        ST_DISC: r_d <= w_disc;
        ST_UPDT: begin
          r_len <= w_len_nxt;
          r_r   <= r_r + 3'd1;
          if (w_grow) r_b <= r_d;
          for (int k = 0; k < 5; k++) begin
            r_lam[k] <= w_lam_nxt[k];
            r_bp[k]  <= w_grow ? r_lam[k] : w_xb[k];
          end
          // Last iteration: publish results so DONE is high during FINISH
          if (r_r == 3'd4) begin
            r_done    <= 1'b1;
            r_lambda1 <= w_lam_nxt[1];
            r_lambda2 <= w_lam_nxt[2];
            r_ldeg    <= w_len_nxt;
            r_no_err  <= w_no_err;
            r_fail    <= w_fail;
`ifdef RS_BM_OMEGA_EN
            r_omega0  <= r_syn[0];
            r_omega1  <= r_syn[1] ^ gf_mul(w_lam_nxt[1], r_syn[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY     = (r_state != ST_IDLE);
  assign DONE     = r_done;
  assign LAMBDA1  = r_lambda1;
  assign LAMBDA2  = r_lambda2;
  assign L_DEG    = r_ldeg;
  assign NO_ERROR = r_no_err;
  assign FAIL     = r_fail;
`ifdef RS_BM_OMEGA_EN
  assign OMEGA0   = r_omega0;
  assign OMEGA1   = r_omega1;
`endif

endmodule

// File: tb/tb_rs_berlekamp_massey.sv
// Scoreboard bench for rs_berlekamp_massey: expected locators are queued per job and checked at DONE.
module tb_rs_berlekamp_massey;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] SYN_IN = 4'h0;
  logic       SYN_VALID = 1'b0;
  logic       BUSY, DONE, NO_ERROR, FAIL;
  logic [3:0] LAMBDA1, LAMBDA2;
  logic [2:0] L_DEG;
`ifdef RS_BM_OMEGA_EN
  logic [3:0] OMEGA0, OMEGA1;
`endif

  rs_berlekamp_massey dut (
    .CLK(CLK), .RESET(RESET), .SYN_IN(SYN_IN), .SYN_VALID(SYN_VALID),
    .BUSY(BUSY), .DONE(DONE), .LAMBDA1(LAMBDA1), .LAMBDA2(LAMBDA2),
    .L_DEG(L_DEG), .NO_ERROR(NO_ERROR), .FAIL(FAIL)
`ifdef RS_BM_OMEGA_EN
    , .OMEGA0(OMEGA0), .OMEGA1(OMEGA1)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] l1;
    logic [3:0] l2;
    logic [2:0] ldeg;
    logic       ne;
    logic       fl;
  } res_t;

  res_t exp_q[$];
  res_t exp_r, got;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  function automatic res_t mk(input logic [3:0] l1, input logic [3:0] l2, input logic [2:0] ldeg,
                              input logic ne, input logic fl);
    res_t r;
    r.l1 = l1; r.l2 = l2; r.ldeg = ldeg; r.ne = ne; r.fl = fl;
    return r;
  endfunction

  // Sends S1..S4 (gap idle cycles between symbols) and optionally waits up to 20 edges for DONE.
  task automatic drive_job(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] s3, input int gap, input bit toggle,
                           input bit do_wait, output int latency);
    logic [3:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    latency = -1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      SYN_IN = s[k];
      SYN_VALID = 1'b1;
      @(posedge CLK); #1;
      SYN_VALID = 1'b0;
      if (k < 3) repeat (gap) @(posedge CLK);
    end
    if (do_wait) begin
      for (int c = 1; c <= 20; c++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (DONE === 1'b1) begin
          latency = c;
          break;
        end
        if (toggle) begin
          SYN_VALID = ~SYN_VALID;
          SYN_IN = 4'($urandom);
        end
      end
    end
    SYN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    #2 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_cmp++;
    if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", DONE); end
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== mk(4'h0, 4'h0, 3'd0, 1'b0, 1'b0)) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", got);
    end
`ifdef RS_BM_OMEGA_EN
    n_cmp++;
    if ({OMEGA0, OMEGA1} !== 8'h00) begin
      n_err++; $display("FAIL reset_omega: got %h expected 00", {OMEGA0, OMEGA1});
    end
`endif
    RESET = 1'b0;
  endtask

  task automatic test_zero;
    exp_q.push_back(mk(4'h0, 4'h0, 3'd0, 1'b1, 1'b0));
    drive_job(4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 1'b1, lat);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL zero_latency: got %0d expected 8", lat); end
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL zero_result: got %h expected %h", got, exp_r); end
    @(negedge CLK);
    n_cmp++;
    if (DONE !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b expected 0", DONE); end
  endtask

  task automatic test_single;
    exp_q.push_back(mk(4'h1, 4'h0, 3'd1, 1'b0, 1'b0));
    drive_job(4'h1, 4'h1, 4'h1, 4'h1, 0, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL single_pos0: got %h expected %h", got, exp_r); end
    exp_q.push_back(mk(4'h2, 4'h0, 3'd1, 1'b0, 1'b0));
    drive_job(4'h2, 4'h4, 4'h8, 4'h3, 1, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL single_pos1: got %h expected %h", got, exp_r); end
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL single_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_two;
    exp_q.push_back(mk(4'h3, 4'h2, 3'd2, 1'b0, 1'b0));
    drive_job(4'h3, 4'h5, 4'h9, 4'h2, 0, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL two_errors: got %h expected %h", got, exp_r); end
`ifdef RS_BM_OMEGA_EN
    n_cmp++;
    if ({OMEGA0, OMEGA1} !== 8'h30) begin
      n_err++; $display("FAIL two_omega: got %h expected 30", {OMEGA0, OMEGA1});
    end
`endif
  endtask

  task automatic test_overflow;
    exp_q.push_back(mk(4'h0, 4'h0, 3'd4, 1'b0, 1'b1));
    drive_job(4'h0, 4'h0, 4'h0, 4'h1, 0, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL overflow_fail: got %h expected %h", got, exp_r); end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(mk(4'h3, 4'h2, 3'd2, 1'b0, 1'b0));
    drive_job(4'h3, 4'h5, 4'h9, 4'h2, 2, 1'b1, 1'b1, lat);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL gap_latency: got %0d expected 8", lat); end
    n_cmp++;
    if (BUSY !== 1'b1) begin n_err++; $display("FAIL busy_in_finish: got %b expected 1", BUSY); end
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL gap_toggle_result: got %h expected %h", got, exp_r); end
    exp_q.push_back(mk(4'h1, 4'h0, 3'd1, 1'b0, 1'b0));
    drive_job(4'h1, 4'h1, 4'h1, 4'h1, 0, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL next_job_result: got %h expected %h", got, exp_r); end
  endtask

  task automatic test_reset_mid;
    int seen;
    drive_job(4'h3, 4'h5, 4'h9, 4'h2, 0, 1'b0, 1'b0, lat);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== mk(4'h0, 4'h0, 3'd0, 1'b0, 1'b0)) begin
      n_err++; $display("FAIL abort_outputs: got %h expected 0", got);
    end
    @(posedge CLK); #1 RESET = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    exp_q.push_back(mk(4'h2, 4'h0, 3'd1, 1'b0, 1'b0));
    drive_job(4'h2, 4'h4, 4'h8, 4'h3, 0, 1'b0, 1'b1, lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {LAMBDA1, LAMBDA2, L_DEG, NO_ERROR, FAIL};
    n_cmp++;
    if (got !== exp_r) begin n_err++; $display("FAIL after_abort: got %h expected %h", got, exp_r); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_single;
    test_two;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
